// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and arithmetic for the round-robin multiply/accumulate arbiter.
package lcv_mul_acc_pkg;

    localparam int OPD_W  = 16;
    localparam int ACC_W  = 33;
    localparam int PROD_W = 2 * OPD_W;

    // One request: signed 16x16 operands plus three 33-bit addends
    typedef struct packed {
        logic signed [OPD_W-1:0] a;
        logic signed [OPD_W-1:0] b;
        logic [ACC_W-1:0]        c;
        logic [ACC_W-1:0]        d;
        logic [ACC_W-1:0]        e;
    } mac_op_t;

    // Result payload; the requester tag travels beside it at ID_W bits
    typedef struct packed {
        logic [ACC_W-1:0] data;
    } mac_resp_t;

    // Signed product sign-extended to 33 bits, then summed with wrap-around
    function automatic logic [ACC_W-1:0] macSum(
        input logic signed [OPD_W-1:0] a,
        input logic signed [OPD_W-1:0] b,
        input logic [ACC_W-1:0]        c,
        input logic [ACC_W-1:0]        d,
        input logic [ACC_W-1:0]        e
    );
        logic signed [PROD_W-1:0] prod;
        prod = a * b;
        return {prod[PROD_W-1], prod} + c + d + e;
    endfunction

endpackage

// File: rtl/LcvMulAcc32Del1.sv
// Single-cycle-latency multiply and three-way accumulate (maps onto one DSP slice).
module LcvMulAcc32Del1
    import lcv_mul_acc_pkg::*;
(
    input  logic                    i_clk,
    input  logic signed [OPD_W-1:0] i_a,
    input  logic signed [OPD_W-1:0] i_b,
    input  logic [ACC_W-1:0]        i_c,
    input  logic [ACC_W-1:0]        i_d,
    input  logic [ACC_W-1:0]        i_e,
    output logic [ACC_W-1:0]        o_outp
);

    logic [ACC_W-1:0] r_outp;

    // Register the combined product-and-sum; validity is tracked by the caller
    always_ff @(posedge i_clk) begin
        r_outp <= macSum(i_a, i_b, i_c, i_d, i_e);
    end

    assign o_outp = r_outp;

endmodule

// File: rtl/lcv_mul_acc_resp_fifo.sv
// Synchronous response FIFO holding requester tag and result, with occupancy count.
module lcv_mul_acc_resp_fifo
    import lcv_mul_acc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [ID_W-1:0]              i_pushId,
    input  mac_resp_t                    i_pushData,
    input  logic                         i_pop,
    output logic [ID_W-1:0]              o_headId,
    output mac_resp_t                    o_headData,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  r_idMem   [DEPTH];
    mac_resp_t        r_dataMem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_doPush;
    logic             w_doPop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_doPush = i_push && !w_full;
    assign w_doPop  = i_pop && !w_empty;

    // Pointer and occupancy bookkeeping; reset empties the buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array is not reset; stale entries are unreachable once count is zero
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_idMem[r_wrPtr]   <= i_pushId;
            r_dataMem[r_wrPtr] <= i_pushData;
        end
    end

    assign o_headId   = w_empty ? '0 : r_idMem[r_rdPtr];
    assign o_headData = r_dataMem[r_rdPtr];
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule

// File: rtl/lcv_mul_acc_arb.sv
// Round-robin arbiter sharing one registered MAC among NUM_REQ requesters,
// with credit-gated issue so that every issued result has a FIFO slot.
module lcv_mul_acc_arb
    import lcv_mul_acc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*OPD_W-1:0] i_req_a,
    input  logic [NUM_REQ*OPD_W-1:0] i_req_b,
    input  logic [NUM_REQ*ACC_W-1:0] i_req_c,
    input  logic [NUM_REQ*ACC_W-1:0] i_req_d,
    input  logic [NUM_REQ*ACC_W-1:0] i_req_e,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready,
    output logic [ID_W-1:0]          o_resp_id,
    output logic [ACC_W-1:0]         o_resp_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic             w_found;
    logic [ID_W-1:0]  w_grantIdx;
    mac_op_t          w_selOp;
    logic [SUM_W-1:0] w_inflight;
    logic             w_creditOk;
    logic             w_accept;
    logic             w_pop;

    logic [ID_W-1:0]  r_rrPtr;
    logic             r_s1Valid;
    mac_op_t          r_s1Op;
    logic [ID_W-1:0]  r_s1Id;
    logic             r_s2Valid;
    logic [ID_W-1:0]  r_s2Id;

    logic [ACC_W-1:0] w_macOut;
    mac_resp_t        w_pushResp;
    mac_resp_t        w_headResp;
    logic             w_fifoEmpty;
    logic [CNT_W-1:0] w_fifoCount;

    // Round-robin pick: lowest valid index at or above the pointer, else lowest overall
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (i >= int'(r_rrPtr))) begin
                w_found    = 1'b1;
                w_grantIdx = ID_W'(i);
            end
        end
        if (!w_found) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (i_req_valid[i]) begin
                    w_found    = 1'b1;
                    w_grantIdx = ID_W'(i);
                end
            end
        end
    end

    // Steer the granted requester's operands toward stage 1
    always_comb begin
        w_selOp = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantIdx == ID_W'(i)) begin
                w_selOp.a = i_req_a[OPD_W*i +: OPD_W];
                w_selOp.b = i_req_b[OPD_W*i +: OPD_W];
                w_selOp.c = i_req_c[ACC_W*i +: ACC_W];
                w_selOp.d = i_req_d[ACC_W*i +: ACC_W];
                w_selOp.e = i_req_e[ACC_W*i +: ACC_W];
            end
        end
    end

    // Every op in stage 1, stage 2 or the FIFO holds a credit; a same-cycle pop frees one
    assign w_pop      = !w_fifoEmpty && i_resp_ready;
    assign w_inflight = SUM_W'(r_s1Valid) + SUM_W'(r_s2Valid) + SUM_W'(w_fifoCount) - SUM_W'(w_pop);
    assign w_creditOk = (w_inflight < SUM_W'(FIFO_DEPTH));

    // Ready is withheld during reset so no requester believes an op was taken
    assign w_accept    = w_found && w_creditOk && !i_rst;
    assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_grantIdx) : '0;

    // Pipeline valids and the round-robin pointer, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_rrPtr   <= '0;
        end else begin
            r_s1Valid <= w_accept;
            r_s2Valid <= r_s1Valid;
            if (w_accept) begin
                r_rrPtr <= (w_grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + ID_W'(1);
            end
        end
    end

    // Operand and tag registers carry data only and are qualified by the valids
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_s1Op <= w_selOp;
            r_s1Id <= w_grantIdx;
        end
        r_s2Id <= r_s1Id;
    end

    LcvMulAcc32Del1 u_mac (
        .i_clk  (i_clk),
        .i_a    (r_s1Op.a),
        .i_b    (r_s1Op.b),
        .i_c    (r_s1Op.c),
        .i_d    (r_s1Op.d),
        .i_e    (r_s1Op.e),
        .o_outp (w_macOut)
    );

    assign w_pushResp = '{data: w_macOut};

    lcv_mul_acc_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_respFifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (r_s2Valid),
        .i_pushId   (r_s2Id),
        .i_pushData (w_pushResp),
        .i_pop      (w_pop),
        .o_headId   (o_resp_id),
        .o_headData (w_headResp),
        .o_empty    (w_fifoEmpty),
        .o_count    (w_fifoCount)
    );

    assign o_resp_valid = !w_fifoEmpty;
    assign o_resp_data  = w_headResp.data;

endmodule

// File: tb/tb_lcv_mul_acc_arb.sv
// Directed bench for lcv_mul_acc_arb: a transaction-level model checked every cycle,
// plus literal expectations on grant order, latency and hand-computed results.
module tb_lcv_mul_acc_arb;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ*16-1:0] reqA;
    logic [NREQ*16-1:0] reqB;
    logic [NREQ*33-1:0] reqC;
    logic [NREQ*33-1:0] reqD;
    logic [NREQ*33-1:0] reqE;
    logic              respValid;
    logic              respReady;
    logic [IDW-1:0]    respId;
    logic [32:0]       respData;

    int checkCount = 0;
    int errCount   = 0;
    int cyc        = 0;
    bit checkEn    = 1'b0;

    typedef struct {
        int          id;
        logic [32:0] data;
        int          avail;
    } expEntry_t;

    typedef struct {
        int          id;
        logic [32:0] data;
    } obsEntry_t;

    expEntry_t expQ[$];
    obsEntry_t obsQ[$];
    int        grantLog[$];
    int        grantCyc[$];
    int        respRiseCyc   = -1;
    bit        prevRespValid = 1'b0;
    int        mdlPtr        = 0;
    bit        acceptFlag    = 1'b0;
    int        acceptIdx     = 0;
    int        opsLeft [NREQ];
    int        seqNo   [NREQ];

    logic [15:0] aTab [4] = '{16'h04D2, 16'h8000, 16'h7FFF, 16'hFFF9};
    logic [15:0] bTab [4] = '{16'hFFFD, 16'h8000, 16'h0002, 16'h03E8};
    logic [32:0] cTab [4] = '{33'h0_0000_0064, 33'h1_0000_0000, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF};

    lcv_mul_acc_arb #(
        .NUM_REQ    (NREQ),
        .ID_W       (IDW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_a      (reqA),
        .i_req_b      (reqB),
        .i_req_c      (reqC),
        .i_req_d      (reqD),
        .i_req_e      (reqE),
        .o_resp_valid (respValid),
        .i_resp_ready (respReady),
        .o_resp_id    (respId),
        .o_resp_data  (respData)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to time model responses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain-arithmetic result of requester g's current operands, wrapped to 33 bits
    function automatic logic [32:0] mdlResult(input int g);
        longint s;
        s = longint'($signed(reqA[16*g +: 16])) * longint'($signed(reqB[16*g +: 16]))
          + longint'($signed(reqC[33*g +: 33]))
          + longint'($signed(reqD[33*g +: 33]))
          + longint'($signed(reqE[33*g +: 33]));
        return s[32:0];
    endfunction

    task automatic setOp(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [32:0] c, input logic [32:0] d, input logic [32:0] e);
        reqA[16*i +: 16] = a;
        reqB[16*i +: 16] = b;
        reqC[33*i +: 33] = c;
        reqD[33*i +: 33] = d;
        reqE[33*i +: 33] = e;
    endtask

    task automatic loadOp(input int i);
        int k;
        k = (seqNo[i] + i) % 4;
        setOp(i, aTab[k], bTab[(k+1)%4], cTab[(k+2)%4], cTab[(k+3)%4], cTab[k]);
    endtask

    // Advance one cycle; a requester that just transferred moves to its next op or drops valid
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (acceptFlag) begin
            opsLeft[acceptIdx]--;
            seqNo[acceptIdx]++;
            if (opsLeft[acceptIdx] > 0) loadOp(acceptIdx);
            else reqValid[acceptIdx] = 1'b0;
        end
    endtask

    task automatic runCycles(input int n);
        for (int j = 0; j < n; j++) applyStimulus();
    endtask

    task automatic runUntilIdle(input int maxCyc);
        bit idle;
        idle = 1'b0;
        for (int j = 0; j < maxCyc && !idle; j++) begin
            applyStimulus();
            idle = (expQ.size() == 0);
            for (int i = 0; i < NREQ; i++) if (opsLeft[i] != 0) idle = 1'b0;
        end
        checkOutput("idle_timeout", 64'(idle), 64'd1);
    endtask

    task automatic clearLogs();
        grantLog.delete();
        grantCyc.delete();
        obsQ.delete();
        respRiseCyc = -1;
    endtask

    task automatic startReq(input int i, input int n);
        opsLeft[i]  = n;
        loadOp(i);
        reqValid[i] = 1'b1;
    endtask

    // Per-cycle compare against the transaction model, then advance the model
    always @(negedge clk) begin
        bit          expFound;
        int          expGrant;
        bit          expVisible;
        bit          expPop;
        bit          expCredit;
        logic [NREQ-1:0] expReady;
        acceptFlag = 1'b0;
        if (rst) begin
            expQ.delete();
            mdlPtr        = 0;
            prevRespValid = 1'b0;
        end else if (checkEn) begin
            expFound = 1'b0;
            expGrant = 0;
            for (int off = 0; off < NREQ; off++) begin
                int idx;
                idx = (mdlPtr + off) % NREQ;
                if (!expFound && reqValid[idx]) begin
                    expFound = 1'b1;
                    expGrant = idx;
                end
            end
            expVisible = (expQ.size() > 0) && (expQ[0].avail <= cyc);
            expPop     = expVisible && respReady;
            expCredit  = (expQ.size() - (expPop ? 1 : 0)) < DEPTH;
            expReady   = (expFound && expCredit) ? (NREQ'(1) << expGrant) : '0;

            checkOutput("req_ready", 64'(reqReady), 64'(expReady));
            checkOutput("resp_valid", 64'(respValid), 64'(expVisible));
            if (expVisible) begin
                checkOutput("resp_id", 64'(respId), 64'(expQ[0].id));
                checkOutput("resp_data", 64'(respData), 64'(expQ[0].data));
            end

            for (int i = 0; i < NREQ; i++) begin
                if (reqReady[i] && reqValid[i]) begin
                    grantLog.push_back(i);
                    grantCyc.push_back(cyc);
                end
            end
            if (respValid && respReady) obsQ.push_back('{int'(respId), respData});
            if (respValid && !prevRespValid) respRiseCyc = cyc;
            prevRespValid = respValid;

            if (expPop) void'(expQ.pop_front());
            if (expFound && expCredit) begin
                expQ.push_back('{expGrant, mdlResult(expGrant), cyc + 3});
                mdlPtr     = (expGrant + 1) % NREQ;
                acceptFlag = 1'b1;
                acceptIdx  = expGrant;
            end
        end
    end

    // Hard stop so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        rst       = 1'b1;
        reqValid  = '0;
        respReady = 1'b1;
        reqA = '0; reqB = '0; reqC = '0; reqD = '0; reqE = '0;
        for (int i = 0; i < NREQ; i++) begin
            opsLeft[i] = 0;
            seqNo[i]   = 0;
        end
        runCycles(2);
        rst     = 1'b0;
        checkEn = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
        checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
        checkOutput("rst_resp_id", 64'(respId), 64'd0);

        $display("[TB] single op: 3*-4+10+1+2");
        clearLogs();
        setOp(0, 16'd3, 16'hFFFC, 33'd10, 33'd1, 33'd2);
        opsLeft[0]  = 1;
        reqValid[0] = 1'b1;
        runUntilIdle(30);
        checkOutput("single_count", 64'(obsQ.size()), 64'd1);
        checkOutput("single_id", 64'(obsQ[0].id), 64'd0);
        checkOutput("single_data", 64'(obsQ[0].data), 64'd1);
        checkOutput("single_latency", 64'(respRiseCyc - grantCyc[0]), 64'd3);

        $display("[TB] 33-bit wrap");
        clearLogs();
        setOp(1, 16'h7FFF, 16'h7FFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF);
        opsLeft[1]  = 1;
        reqValid[1] = 1'b1;
        runUntilIdle(30);
        checkOutput("wrap_id", 64'(obsQ[0].id), 64'd1);
        checkOutput("wrap_data", 64'(obsQ[0].data), 64'(33'h1_3FFE_FFFE));
        checkOutput("wrap_signed", 64'(longint'($signed(obsQ[0].data))), 64'(-64'sd3221291010));

        $display("[TB] round robin, all requesters");
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        clearLogs();
        for (int i = 0; i < NREQ; i++) startReq(i, 3);
        runUntilIdle(60);
        checkOutput("rr_grants", 64'(grantLog.size()), 64'd12);
        for (int j = 0; j < 5; j++) begin
            checkOutput("rr_grant_order", 64'(grantLog[j]), 64'(j % NREQ));
            checkOutput("rr_resp_order", 64'(obsQ[j].id), 64'(j % NREQ));
        end
        checkOutput("rr_back_to_back", 64'(grantCyc[11] - grantCyc[0]), 64'd11);

        $display("[TB] backpressure");
        clearLogs();
        respReady = 1'b0;
        for (int i = 0; i < NREQ; i++) startReq(i, 2);
        runCycles(10);
        checkOutput("bp_accepts", 64'(grantLog.size()), 64'd4);
        checkOutput("bp_ready_low", 64'(reqReady), 64'd0);
        respReady = 1'b1;
        applyStimulus();
        checkOutput("bp_one_grant", 64'(grantLog.size()), 64'd5);
        checkOutput("bp_one_pop", 64'(obsQ.size()), 64'd1);
        runUntilIdle(60);
        checkOutput("bp_total", 64'(obsQ.size()), 64'd8);
        for (int j = 0; j < 4; j++) checkOutput("bp_drain_order", 64'(obsQ[j].id), 64'(j));

        $display("[TB] fairness gap");
        clearLogs();
        startReq(2, 1);
        for (int n = 0; n < 10 && opsLeft[2] != 0; n++) applyStimulus();
        startReq(1, 1);
        startReq(3, 1);
        runUntilIdle(40);
        checkOutput("fair_count", 64'(grantLog.size()), 64'd3);
        checkOutput("fair_g0", 64'(grantLog[0]), 64'd2);
        checkOutput("fair_g1", 64'(grantLog[1]), 64'd3);
        checkOutput("fair_g2", 64'(grantLog[2]), 64'd1);

        $display("[TB] reset mid-flight");
        clearLogs();
        respReady = 1'b0;
        startReq(0, 1);
        startReq(1, 1);
        startReq(2, 1);
        runCycles(6);
        checkOutput("mid_queued", 64'(grantLog.size()), 64'd3);
        startReq(1, 1);
        startReq(3, 1);
        rst = 1'b1;
        applyStimulus();
        rst       = 1'b0;
        respReady = 1'b1;
        checkOutput("mid_resp_valid", 64'(respValid), 64'd0);
        runUntilIdle(40);
        checkOutput("mid_grants", 64'(grantLog.size()), 64'd5);
        checkOutput("mid_first_after_rst", 64'(grantLog[3]), 64'd1);
        checkOutput("mid_second_after_rst", 64'(grantLog[4]), 64'd3);
        checkOutput("mid_no_stale", 64'(obsQ.size()), 64'd2);
        checkOutput("mid_resp0_id", 64'(obsQ[0].id), 64'd1);
        checkOutput("mid_resp1_id", 64'(obsQ[1].id), 64'd3);

        runCycles(3);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lcv_mul_acc_arb.md
# lcv_mul_acc_arb

Round-robin arbiter that shares one registered 16x16 multiply / three-way-accumulate DSP unit (LcvMulAcc32Del1) between NUM_REQ requesters. Each requester has a valid/ready request port carrying operands. Results return on a single tagged response port with backpressure, buffered by an internal FIFO. A credit scheme guarantees no issued result is ever dropped. The block sits between the scalar execution lanes and the single DSP48 slice allotted to multiply-accumulate.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), requester tag width
- FIFO_DEPTH, 4, response buffer entries (min 3 for full throughput)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*16  signed multiplicand per requester, requester i at [16*i +: 16]
- req_b  in  NUM_REQ*16  signed multiplier, same packing
- req_c, req_d, req_e  in  NUM_REQ*33 each  signed addends, requester i at [33*i +: 33]
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_W  index of the requester that issued the op
- resp_data  out  33  signed a*b+c+d+e

## Operation
- Request handshake: transfer when req_valid[i] && req_ready[i]. Requesters hold operands stable while valid and not ready.
- Arbitration: rr_ptr (ID_W bits). Grant goes to the lowest index >= rr_ptr with req_valid set; if none, the search wraps to 0. After a grant, rr_ptr = (grant+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
- req_ready[grant] = 1 only when credit_ok. All other req_ready bits are 0. req_ready depends combinationally on req_valid.
- credit_ok = (s1_v + s2_v + fifo_cnt - pop) < FIFO_DEPTH, where pop = resp_valid && resp_ready in the same cycle.
- Stage s1: the accepted operands and id are registered; s1_v is set.
- Stage s2: the MAC registers s1's result; s2_v and s2_id follow.
- When s2_v is set, {s2_id, MAC outp} is pushed into the FIFO.
- Response port presents the FIFO head. Push and pop may occur in the same cycle. The FIFO never overflows, by construction of the credit rule.
- Arithmetic: the 32-bit signed product is sign-extended and summed with c, d and e. The result is truncated to 33 bits (two's-complement wrap, no saturation or overflow flag).
- Reset: s1_v = s2_v = 0, fifo_cnt = 0, FIFO pointers = 0, rr_ptr = 0. Any in-flight or buffered results are discarded. Operand and data registers are not reset.

## Timing
- Outputs after reset: req_ready = 0 until a valid request is seen, resp_valid = 0, resp_id = 0, resp_data = don't-care while resp_valid = 0.
- Latency: a request accepted at edge k gives resp_valid = 1 after edge k+2 when the FIFO was empty. A deeper FIFO adds one cycle per queued entry.
- Throughput: 1 op/cycle sustained when resp_ready = 1 and FIFO_DEPTH >= 3.
- Backpressure: with resp_ready = 0, at most FIFO_DEPTH ops are accepted, then req_ready = 0 everywhere. The cycle that resp_ready rises, one new grant is allowed.
- resp_valid/resp_id/resp_data remain stable while resp_valid && !resp_ready.
- FIFO full and empty pointers wrap modulo FIFO_DEPTH. Count uses $clog2(FIFO_DEPTH+1) bits.
- rst asserted mid-operation: the next edge yields the reset state. Requests held valid across the reset are re-arbitrated starting from index 0.

## Structure
- Package lcv_mul_acc_pkg:
  - localparams OPD_W = 16, ACC_W = 33.
  - typedef mac_op_t struct {a, b, c, d, e}.
  - typedef mac_resp_t struct parameterized by ID_W via an explicit width field, or by a separate id logic.
- Sub-modules:
  - One instance of LcvMulAcc32Del1 as the datapath.
  - One internal FIFO sub-module, lcv_mul_acc_resp_fifo (sync, 1 clk, count output).
- The round-robin picker stays inline.

## Test plan
- Single op: rst then req 0 with a=3, b=-4, c=10, d=1, e=2, accepted at edge k. Expect resp_valid after k+2 with id=0, data=1.
- Wrap: a=0x7FFF, b=0x7FFF, c=d=e=0x0_FFFFFFFF (33-bit max positive = 2^32-1). Expect data = (0x3FFF0001 + 3*(2^32-1)) mod 2^33, interpreted as signed.
- Round robin: all 4 requesters held valid, resp_ready = 1. Grants go 0,1,2,3,0,... one per cycle. resp_id follows the same order with 2-cycle lag.
- Backpressure: resp_ready = 0, all requesters valid. Exactly 4 accepts, then req_ready = 0. Response holds stable. Raising resp_ready drains in order with one new grant per pop.
- Fairness gap: only req 2 valid, then req 1 and 3 valid. Order is 2, 3, 1 (rr_ptr=3 after the grant to 2).
- Reset mid-flight: 3 ops queued, rst for 1 cycle. Next cycle resp_valid = 0 and rr_ptr = 0. No stale response ever appears.
